// File: rtl/src_ctrl_pkg.sv
// ============================================================================
// Module  : src_ctrl_pkg
// Brief   : Shared state encoding, opcodes and ALU codes for control_unit.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package src_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_INCPC = 5'b11100;

  // Register-register ALU ops pass their opcode straight to the ALU.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module  : control_unit
// Brief   : Multi-cycle CPU control FSM: fetch (T0-T2), decode/execute (T3-T7).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
  import src_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_rdy,
  output logic        Pout,
  output logic        MDROut,
  output logic        ZLOout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        Pen,
  output logic        MARen,
  output logic        MDRen,
  output logic        IRen,
  output logic        Yen,
  output logic        Zen,
  output logic        Rin,
  output logic        ConIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_control,
  output logic        run,
  output logic        illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_op;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  always_ff @(posedge clk) begin
    if (clr) r_state <= ST_RST;
    else     r_state <= w_next;
  end

  always_comb begin
    Pout = 1'b0; MDROut = 1'b0; ZLOout = 1'b0; Cout = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Pen = 1'b0; MARen = 1'b0; MDRen = 1'b0; IRen = 1'b0; Yen = 1'b0; Zen = 1'b0;
    Rin = 1'b0; ConIn = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Read = 1'b0; Write = 1'b0; alu_control = 5'b00000; illegal = 1'b0;
    run    = (r_state != ST_HALT);
    w_next = ST_RST;

    case (r_state)
      ST_RST: w_next = ST_T0;

      ST_T0: begin
        Pout = 1'b1; MARen = 1'b1; Zen = 1'b1; alu_control = ALU_INCPC;
        w_next = ST_T1;
      end

      // Memory states hold here until the access completes.
      ST_T1: begin
        ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1;
        w_next = mem_rdy ? ST_T2 : ST_T1;
      end

      ST_T2: begin
        MDROut = 1'b1; IRen = 1'b1;
        w_next = ST_T3;
      end

      ST_T3: begin
        w_next = ST_T4;
        if (w_op == OP_LD || w_op == OP_LDI || w_op == OP_ST) begin
          Grb = 1'b1; BAout = 1'b1; Yen = 1'b1;
        end else if (is_alu_op(w_op) || w_op == OP_ADDI) begin
          Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
        end else if (w_op == OP_BR) begin
          Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1;
        end else if (w_op == OP_HALT) begin
          w_next = ST_HALT;
        end else begin
          illegal = (w_op != OP_NOP);
          w_next  = ST_T0;
        end
      end

      ST_T4: begin
        w_next = ST_T5;
        if (w_op == OP_LD || w_op == OP_LDI || w_op == OP_ST || w_op == OP_ADDI) begin
          Cout = 1'b1; Zen = 1'b1; alu_control = ALU_ADD;
        end else if (is_alu_op(w_op)) begin
          Grc = 1'b1; Rout = 1'b1; Zen = 1'b1; alu_control = w_op;
        end else if (w_op == OP_BR) begin
          Pout = 1'b1; Yen = 1'b1;
        end else begin
          w_next = ST_T0;
        end
      end

      ST_T5: begin
        w_next = ST_T0;
        if (w_op == OP_LD || w_op == OP_ST) begin
          ZLOout = 1'b1; MARen = 1'b1;
          w_next = ST_T6;
        end else if (w_op == OP_LDI || w_op == OP_ADDI || is_alu_op(w_op)) begin
          ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_op == OP_BR) begin
          Cout = 1'b1; Zen = 1'b1; alu_control = ALU_ADD;
          w_next = ST_T6;
        end
      end

      ST_T6: begin
        w_next = ST_T0;
        if (w_op == OP_LD) begin
          Read = 1'b1; MDRen = 1'b1;
          w_next = mem_rdy ? ST_T7 : ST_T6;
        end else if (w_op == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1;
          w_next = ST_T7;
        end else if (w_op == OP_BR) begin
          ZLOout = con_ff; Pen = con_ff;
        end
      end

      ST_T7: begin
        w_next = ST_T0;
        if (w_op == OP_LD) begin
          MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_op == OP_ST) begin
          Write  = 1'b1;
          w_next = mem_rdy ? ST_T0 : ST_T7;
        end
      end

      ST_HALT: w_next = ST_HALT;

      default: w_next = ST_RST;
    endcase
  end

endmodule

`default_nettype wire
